crc7_cmd_framer: RTL and testbench

CRC7_CMD_FRAMER -- requirements
Module: crc7_cmd_framer

---
 rtl/crc7_pkg.sv | 21 ++
 rtl/crc7_cmd_framer_if.sv | 32 +++
 rtl/crc7_lfsr_sync.sv | 36 +++
 rtl/crc7_cmd_framer.sv | 121 ++++++++++++
 tb/tb_crc7_cmd_framer.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/crc7_pkg.sv
// crc7_pkg -- shared definitions for the CRC7 command framer.
//   CRC7_W / CRC7_POLY : CRC width and polynomial x^7+x^3+1 (MSB-first form).
//   PAYLOAD_W_DEFAULT  : default payload width (SD-style 40-bit command).
//   state_t            : framer FSM states. ST_END only exists when
//                        CRC7_CMD_FRAMER_END_BIT_EN is defined.
package crc7_pkg;

  localparam int                CRC7_W            = 7;
  localparam logic [CRC7_W-1:0] CRC7_POLY         = 7'h09;
  localparam int                PAYLOAD_W_DEFAULT = 40;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_CRC  = 2'd2
`ifdef CRC7_CMD_FRAMER_END_BIT_EN
    , ST_END = 2'd3
`endif
  } state_t;

endpackage

// File: rtl/crc7_cmd_framer_if.sv
// crc7_cmd_framer_if -- request/stream bundle between a frame requester
// (master) and the framer (slave).
//   start, payload : frame request; accepted on a rising CLK edge where
//                    start=1 and ready=1 (start is ignored while ready=0).
//   stall          : holds the frame in place while high (no bit emitted).
//   abort          : drops the current frame; framer returns to idle.
//   ready          : framer idle and able to accept start.
//   out_valid      : out_bit carries a frame bit this cycle.
//   out_bit        : serial frame bit, payload MSB first, then CRC.
//   done           : pulses with the last frame bit.
interface crc7_cmd_framer_if #(
  parameter int PAYLOAD_W = crc7_pkg::PAYLOAD_W_DEFAULT
);
  logic                 start;
  logic [PAYLOAD_W-1:0] payload;
  logic                 stall;
  logic                 abort;
  logic                 ready;
  logic                 out_valid;
  logic                 out_bit;
  logic                 done;

  modport master (
    output start, payload, stall, abort,
    input  ready, out_valid, out_bit, done
  );

  modport slave (
    input  start, payload, stall, abort,
    output ready, out_valid, out_bit, done
  );
endinterface

// File: rtl/crc7_lfsr_sync.sv
// crc7_lfsr_sync -- 7-bit CRC register with synchronous control.
//   CLK       : clock
//   RST       : synchronous active-high reset, loads SEED
//   load      : reload SEED (frame start)
//   enable    : absorb one message bit 'in' (feedback update)
//   shift_out : shift left with zero fill, no feedback (CRC readout)
//   in        : message bit, MSB first
//   crc       : current CRC register; crc[6] is the next readout bit
module crc7_lfsr_sync
  import crc7_pkg::*;
#(
  parameter logic [CRC7_W-1:0] SEED = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load,
  input  logic              enable,
  input  logic              shift_out,
  input  logic              in,
  output logic [CRC7_W-1:0] crc
);

  logic fb;
  assign fb = in ^ crc[CRC7_W-1];

  always_ff @(posedge CLK) begin
    if (RST || load) begin
      crc <= SEED;
    end else if (enable) begin
      crc <= {crc[CRC7_W-2:0], 1'b0} ^ (fb ? CRC7_POLY : '0);
    end else if (shift_out) begin
      crc <= {crc[CRC7_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/crc7_cmd_framer.sv
// crc7_cmd_framer -- serialises a PAYLOAD_W-bit payload MSB first followed
// by its CRC7 (x^7+x^3+1) and, optionally, a closing '1' end bit.
//   CLK, RST  : clock and synchronous active-high reset
//   bus       : crc7_cmd_framer_if slave (start/payload/stall/abort in,
//               ready/out_valid/out_bit/done out)
//   dbg_state : current FSM state
// Parameters: PAYLOAD_W (payload bits), CRC_SEED (CRC value at frame start).
// Macro CRC7_CMD_FRAMER_END_BIT_EN: when defined the frame ends with an END
// bit (PAYLOAD_W+8 bits, done on the end bit); otherwise the frame is
// PAYLOAD_W+7 bits and done marks the 7th CRC bit.
module crc7_cmd_framer
  import crc7_pkg::*;
#(
  parameter int                PAYLOAD_W = PAYLOAD_W_DEFAULT,
  parameter logic [CRC7_W-1:0] CRC_SEED  = 7'h00
) (
  input  logic                CLK,
  input  logic                RST,
  crc7_cmd_framer_if.slave    bus,
  output state_t              dbg_state
);

  localparam int               CNT_W     = $clog2(PAYLOAD_W + 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(PAYLOAD_W - 1);
  localparam logic [2:0]       LAST_CRC  = 3'(CRC7_W - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [2:0]           crc_cnt_q;
  logic [PAYLOAD_W-1:0] shreg_q;
  logic [CRC7_W-1:0]    crc;
  logic                 accept;
  logic                 advance;
  logic                 ready_c, valid_c, bit_c, done_c;

  // advance: a busy cycle that neither stalls nor aborts consumes one bit.
  assign accept  = (state_q == ST_IDLE) && bus.start;
  assign advance = (state_q != ST_IDLE) && !bus.abort && !bus.stall;

  crc7_lfsr_sync #(.SEED(CRC_SEED)) u_crc (
    .CLK       (CLK),
    .RST       (RST),
    .load      (accept),
    .enable    (advance && (state_q == ST_DATA)),
    .shift_out (advance && (state_q == ST_CRC)),
    .in        (shreg_q[PAYLOAD_W-1]),
    .crc       (crc)
  );

  always_comb begin
    state_d = state_q;
    ready_c = 1'b0;
    valid_c = 1'b0;
    bit_c   = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_c = 1'b1;
        if (bus.start) state_d = ST_DATA;
      end
      ST_DATA: begin
        valid_c = advance;
        bit_c   = shreg_q[PAYLOAD_W-1];
        if (advance && (cnt_q == LAST_DATA)) state_d = ST_CRC;
      end
      ST_CRC: begin
        valid_c = advance;
        bit_c   = crc[CRC7_W-1];
        if (advance && (crc_cnt_q == LAST_CRC)) begin
`ifdef CRC7_CMD_FRAMER_END_BIT_EN
          state_d = ST_END;
`else
          state_d = ST_IDLE;
          done_c  = 1'b1;
`endif
        end
      end
`ifdef CRC7_CMD_FRAMER_END_BIT_EN
      ST_END: begin
        valid_c = advance;
        bit_c   = 1'b1;
        if (advance) begin
          state_d = ST_IDLE;
          done_c  = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    // Abort wins over stall and over any state progress.
    if ((state_q != ST_IDLE) && bus.abort) state_d = ST_IDLE;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      crc_cnt_q <= '0;
      shreg_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        shreg_q   <= bus.payload;
        cnt_q     <= '0;
        crc_cnt_q <= '0;
      end else if (advance && (state_q == ST_DATA)) begin
        shreg_q <= shreg_q << 1;
        cnt_q   <= cnt_q + CNT_W'(1);
      end else if (advance && (state_q == ST_CRC)) begin
        crc_cnt_q <= crc_cnt_q + 3'd1;
      end
    end
  end

  assign bus.ready     = ready_c;
  assign bus.out_valid = valid_c;
  assign bus.out_bit   = bit_c;
  assign bus.done      = done_c;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_crc7_cmd_framer.sv
`timescale 1ns/1ps
module tb_crc7_cmd_framer;
  import crc7_pkg::*;

  localparam int PW = 40;
`ifdef CRC7_CMD_FRAMER_END_BIT_EN
  localparam int FLEN = PW + 8;
`else
  localparam int FLEN = PW + 7;
`endif

  // ---------------- clock / reset ----------------
  logic   CLK = 1'b0;
  logic   RST;
  state_t dbg_state;

  crc7_cmd_framer_if #(.PAYLOAD_W(PW)) bus ();

  crc7_cmd_framer #(.PAYLOAD_W(PW), .CRC_SEED(7'h00)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 CLK = ~CLK;

  // ---------------- scoreboard ----------------
  // Each entry: {done expected, frame bit expected}
  logic [1:0] exp_q[$];
  logic [1:0] mon_e;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_bit", bus.out_valid, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          check("frame_bit", {bus.done, bus.out_bit}, mon_e);
        end
      end else begin
        check("done_without_bit", bus.done, 1'b0);
      end
      if (!bus.ready && (bus.stall || bus.abort))
        check("valid_while_held", bus.out_valid, 1'b0);
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [6:0] crc7_ref(input logic [PW-1:0] d);
    logic [6:0] c;
    logic       fb;
    c = 7'h00;
    for (int i = PW - 1; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!bus.ready && n < 100) begin
      tick();
      n++;
    end
    check("ready_timeout", bus.ready, 1'b1);
  endtask

  // Push the first nbits of a 48-bit frame image; done expected on bit FLEN.
  task automatic push_bits(input logic [47:0] stream, input int nbits);
    for (int i = 0; i < nbits; i++)
      exp_q.push_back({(i == FLEN - 1), stream[47-i]});
  endtask

  task automatic stall3();
    bus.stall = 1'b1;
    repeat (3) tick();
    bus.stall = 1'b0;
  endtask

  task automatic run_frame(input logic [PW-1:0] pl, input logic [47:0] stream,
                           input int sa, input int sb, input int rs, input bit with_abort);
    int k, cyc;
    bit sa_done, sb_done;
    wait_ready();
    push_bits(stream, FLEN);
    bus.payload = pl;
    bus.start   = 1'b1;
    bus.abort   = with_abort;
    tick();
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.payload = '0;
    k = 0; cyc = 0; sa_done = 0; sb_done = 0;
    while (k < FLEN && cyc < 500) begin
      if (k == sa && !sa_done) begin
        stall3();
        sa_done = 1;
      end else if (k == sb && !sb_done) begin
        stall3();
        sb_done = 1;
      end else begin
        if (k == rs) begin
          bus.start   = 1'b1;
          bus.payload = PW'({$urandom(), $urandom()});
        end
        tick();
        bus.start = 1'b0;
        k++;
      end
      cyc++;
    end
    check("frame_cycle_budget", k, FLEN);
    check("frame_bits_left", exp_q.size(), 0);
    check("ready_after_done", bus.ready, 1'b1);
    check("state_after_done", dbg_state, ST_IDLE);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [PW-1:0] payload;
    logic [47:0]   stream;
    int            stall_a;
    int            stall_b;
    int            restart_at;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [PW-1:0] pl;

    RST         = 1'b1;
    bus.start   = 1'b0;
    bus.payload = '0;
    bus.stall   = 1'b0;
    bus.abort   = 1'b0;

    vecs[0] = '{40'h4000000000, 48'h400000000095, -1, -1, -1};
    vecs[1] = '{40'h48000001AA, 48'h48000001AA87, 10, 41, -1};
    vecs[2] = '{40'h7700000000, 48'h770000000065, -1, -1, 20};
    pl = 40'h5100000000;
    vecs[3] = '{pl, {pl, crc7_ref(pl), 1'b1}, 0, FLEN - 1, -1};
    for (int i = 4; i < 6; i++) begin
      pl = PW'({$urandom(), $urandom()});
      vecs[i] = '{pl, {pl, crc7_ref(pl), 1'b1},
                  int'($urandom_range(0, FLEN - 1)), int'($urandom_range(0, FLEN - 1)), -1};
    end

    repeat (3) tick();
    RST = 1'b0;
    check("rst_ready",     bus.ready,     1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_bit",   bus.out_bit,   1'b0);
    check("rst_done",      bus.done,      1'b0);
    check("rst_state",     dbg_state,     ST_IDLE);

    for (int i = 0; i < 6; i++)
      run_frame(vecs[i].payload, vecs[i].stream, vecs[i].stall_a, vecs[i].stall_b,
                vecs[i].restart_at, 1'b0);

    // Abort (together with stall) at bit 30, then immediate start+abort in idle.
    wait_ready();
    push_bits(48'h510000000000, 30);
    bus.payload = 40'h5100000000;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (30) tick();
    bus.abort = 1'b1;
    bus.stall = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.stall = 1'b0;
    check("abort_ready", bus.ready, 1'b1);
    check("abort_state", dbg_state, ST_IDLE);
    check("abort_bits_left", exp_q.size(), 0);
    run_frame(40'h4000000000, 48'h400000000095, -1, -1, -1, 1'b1);

    // Reset at bit 15 with start held high; reset must win.
    push_bits(48'h770000000065, 15);
    bus.payload = 40'h7700000000;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (15) tick();
    RST       = 1'b1;
    bus.start = 1'b1;
    tick();
    RST       = 1'b0;
    bus.start = 1'b0;
    check("midrst_ready",     bus.ready,     1'b1);
    check("midrst_out_valid", bus.out_valid, 1'b0);
    check("midrst_out_bit",   bus.out_bit,   1'b0);
    check("midrst_done",      bus.done,      1'b0);
    check("midrst_state",     dbg_state,     ST_IDLE);
    check("midrst_bits_left", exp_q.size(),  0);
    run_frame(40'h48000001AA, 48'h48000001AA87, -1, -1, -1, 1'b0);

    repeat (5) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
